// File: rtl/nor_sweep_pkg.sv
// nor_sweep_pkg: shared types and fixed widths for the NOR gate sweep controller
package nor_sweep_pkg;
   localparam int VEC_W = 4;
   localparam int OUT_W = 3;
   localparam int NUM_VEC = 16;
   localparam int ERR_CNT_W = 5;
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/nor_sweep_ctrl_if.sv
// nor_sweep_ctrl_if: control, gate-facing and result signals of the sweep controller
interface nor_sweep_ctrl_if;
   import nor_sweep_pkg::*;
   logic                 start_i;
   logic                 abort_i;
   logic [VEC_W-1:0]     vec_out_o;
   logic [OUT_W-1:0]     dut_out_i;
   logic                 busy_o;
   logic                 done_o;
   logic                 pass_o;
   logic [ERR_CNT_W-1:0] err_cnt_o;
   logic                 err_valid_o;
   logic [VEC_W-1:0]     err_vec_o;
   modport slave (
      input  start_i, abort_i, dut_out_i,
      output vec_out_o, busy_o, done_o, pass_o, err_cnt_o, err_valid_o, err_vec_o
   );
   modport master (
      output start_i, abort_i, dut_out_i,
      input  vec_out_o, busy_o, done_o, pass_o, err_cnt_o, err_valid_o, err_vec_o
   );
endinterface

// File: rtl/nor_ref_model.sv
// nor_ref_model: expected {e,f,g} of the NOR gate block for vector {d,c,b,a}
module nor_ref_model
   import nor_sweep_pkg::*;
(
   input  logic [VEC_W-1:0] vec_i,
   output logic [OUT_W-1:0] exp_o
);
   logic e, f;
   assign e = ~(vec_i[0] | vec_i[1]);
   assign f = ~(vec_i[2] | vec_i[3]);
   assign exp_o = {e, f, ~(e | f)};
endmodule

// File: rtl/nor_sweep_ctrl.sv
// nor_sweep_ctrl: clocked self-checking sweep of all 16 NOR inputs; NOR_SWEEP_LOOP_EN repeats sweeps forever
module nor_sweep_ctrl
   import nor_sweep_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   nor_sweep_ctrl_if.slave  bus
);
   localparam int HC_W = $clog2(HOLD_CYCLES) + 1;
`ifdef NOR_SWEEP_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   if (HOLD_CYCLES < 1) begin : g_hold_chk
      $error("nor_sweep_ctrl: HOLD_CYCLES must be at least 1");
   end

   state_t               state_q, state_d;
   logic [HC_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic [VEC_W-1:0]     vec_q, vec_d, err_vec_q, err_vec_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d, cnt_inc;
   logic                 err_valid_q, err_valid_d, pass_q, pass_d, done_q, done_d;
   logic [OUT_W-1:0]     exp_v;
   logic                 last, hold_done, sweep_start, sample, mis;

   nor_ref_model u_model (.vec_i(vec_q), .exp_o(exp_v));

   assign last        = vec_q == VEC_W'(NUM_VEC - 1);
   assign hold_done   = hold_cnt_q == HC_W'(HOLD_CYCLES - 1);
   assign sweep_start = !bus.abort_i && bus.start_i && (state_q == IDLE || state_q == DONE);
   assign sample      = !bus.abort_i && state_q == SAMPLE;
   assign mis         = sample && (bus.dut_out_i != exp_v);
   assign cnt_inc     = (mis && err_cnt_q != ERR_CNT_W'(NUM_VEC)) ? err_cnt_q + 1'b1 : err_cnt_q;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state: abort overrides everything; start only honoured when not busy
   always_comb begin
      state_d = state_q;
      if (bus.abort_i) state_d = IDLE;
      else begin
         case (state_q)
            IDLE, DONE: state_d = bus.start_i ? DRIVE : IDLE;
            DRIVE:      state_d = hold_done ? SAMPLE : DRIVE;
            SAMPLE:     state_d = (last && !LOOP) ? DONE : DRIVE;
            default:    state_d = IDLE;
         endcase
      end
   end

   // datapath next values: vector walk, mismatch recording, pass/done at sweep end
   always_comb begin
      hold_cnt_d  = (state_q == DRIVE && state_d == DRIVE) ? hold_cnt_q + 1'b1 : '0;
      vec_d       = vec_q;
      err_cnt_d   = err_cnt_q;
      err_valid_d = err_valid_q;
      err_vec_d   = err_vec_q;
      pass_d      = pass_q;
      done_d      = sample && last;
      if (bus.abort_i || sweep_start) begin
         vec_d  = '0;
         pass_d = 1'b0;
      end
      if (sweep_start) begin
         err_cnt_d   = '0;
         err_valid_d = 1'b0;
         err_vec_d   = '0;
      end else if (sample) begin
         vec_d       = (last && !LOOP) ? vec_q : vec_q + 1'b1;
         err_cnt_d   = cnt_inc;
         err_valid_d = err_valid_q | mis;
         err_vec_d   = (mis && !err_valid_q) ? vec_q : err_vec_q;
         if (last) begin
            pass_d = cnt_inc == '0;
            if (LOOP) begin
               err_cnt_d   = '0;
               err_valid_d = 1'b0;
               err_vec_d   = '0;
            end
         end
      end
   end

   // datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_q  <= '0;
         vec_q       <= '0;
         err_cnt_q   <= '0;
         err_valid_q <= 1'b0;
         err_vec_q   <= '0;
         pass_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         hold_cnt_q  <= hold_cnt_d;
         vec_q       <= vec_d;
         err_cnt_q   <= err_cnt_d;
         err_valid_q <= err_valid_d;
         err_vec_q   <= err_vec_d;
         pass_q      <= pass_d;
         done_q      <= done_d;
      end
   end

   // outputs
   always_comb begin
      bus.busy_o      = state_q == DRIVE || state_q == SAMPLE;
      bus.done_o      = done_q;
      bus.vec_out_o   = vec_q;
      bus.pass_o      = pass_q;
      bus.err_cnt_o   = err_cnt_q;
      bus.err_valid_o = err_valid_q;
      bus.err_vec_o   = err_vec_q;
   end
endmodule

// File: tb/tb_nor_sweep_ctrl.sv
// tb_nor_sweep_ctrl: randomized fault-injection bench for nor_sweep_ctrl against a sweep-level model
module tb_nor_sweep_ctrl;
   import nor_sweep_pkg::*;
`ifdef NOR_SWEEP_LOOP_EN
   localparam int H = 1;
`else
   localparam int H = 4;
`endif
   localparam int SWEEP = NUM_VEC * (H + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int errors = 0;
   int checks = 0;
   logic [2:0] fault_m [NUM_VEC];
   logic [3:0] chk_v;
   logic [2:0] chk_e;
   int m_cnt;
   logic m_valid, m_pass;
   logic [3:0] m_vec;

   nor_sweep_ctrl_if bus ();
   nor_sweep_ctrl #(.HOLD_CYCLES(H)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   nor_ref_model u_ref (.vec_i(chk_v), .exp_o(chk_e));

   always #5 clk = ~clk;

   // gate behaviour: e is 1 only when a,b are both 0; f likewise for c,d; g only when e,f both 0
   function automatic logic [2:0] gate_nor(input logic [3:0] v);
      logic e, f;
      e = v[1:0] == 2'd0;
      f = v[3:2] == 2'd0;
      return {e, f, !e && !f};
   endfunction

   assign bus.dut_out_i = gate_nor(bus.vec_out_o) ^ fault_m[bus.vec_out_o];

   // a vector mismatches exactly when its fault mask is nonzero
   task automatic model_sweep();
      m_cnt = 0;
      m_valid = 1'b0;
      m_vec = 4'd0;
      for (int v = 0; v < NUM_VEC; v++)
         if (fault_m[v] != 3'd0) begin
            if (!m_valid) m_vec = 4'(v);
            m_valid = 1'b1;
            m_cnt++;
         end
      if (m_cnt > 16) m_cnt = 16;
      m_pass = m_cnt == 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
   endtask

   task automatic do_abort();
      bus.abort_i = 1'b1;
      tick();
      bus.abort_i = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.done_o && n < 400);
   endtask

   task automatic clear_faults();
      for (int v = 0; v < NUM_VEC; v++) fault_m[v] = 3'd0;
   endtask

   task automatic random_faults();
      for (int v = 0; v < NUM_VEC; v++)
         fault_m[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if ({bus.vec_out_o, bus.busy_o, bus.done_o, bus.pass_o} !== 7'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got vec=%0d busy=%b done=%b pass=%b want all 0", bus.vec_out_o, bus.busy_o, bus.done_o, bus.pass_o);
      end
      checks++;
      if ({bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o} !== 10'd0) begin
         errors++;
         $display("FAIL reset_err: got cnt=%0d valid=%b vec=%0d want all 0", bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b want 0", bus.busy_o);
      end
   endtask

   task automatic test_ref_model();
      for (int v = 0; v < NUM_VEC; v++) begin
         chk_v = 4'(v);
         #1;
         checks++;
         if (chk_e !== gate_nor(4'(v))) begin
            errors++;
            $display("FAIL ref_model v=%0d: got %b want %b", v, chk_e, gate_nor(4'(v)));
         end
      end
   endtask

   task automatic test_nominal();
      clear_faults();
      do_start();
      for (int i = 0; i < SWEEP; i++) begin
         checks++;
         if ({bus.vec_out_o, bus.busy_o, bus.done_o} !== {4'(i / (H + 1)), 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL nominal_walk i=%0d: got vec=%0d busy=%b done=%b want vec=%0d busy=1 done=0", i, bus.vec_out_o, bus.busy_o, bus.done_o, i / (H + 1));
         end
         tick();
      end
      checks++;
      if ({bus.done_o, bus.busy_o, bus.pass_o, bus.vec_out_o} !== {1'b1, 1'b0, 1'b1, 4'd15}) begin
         errors++;
         $display("FAIL nominal_done: got done=%b busy=%b pass=%b vec=%0d want 1 0 1 15", bus.done_o, bus.busy_o, bus.pass_o, bus.vec_out_o);
      end
      checks++;
      if ({bus.err_cnt_o, bus.err_valid_o} !== 6'd0) begin
         errors++;
         $display("FAIL nominal_err: got cnt=%0d valid=%b want 0 0", bus.err_cnt_o, bus.err_valid_o);
      end
      tick();
      checks++;
      if ({bus.done_o, bus.busy_o, bus.pass_o, bus.vec_out_o} !== {1'b0, 1'b0, 1'b1, 4'd15}) begin
         errors++;
         $display("FAIL nominal_after: got done=%b busy=%b pass=%b vec=%0d want 0 0 1 15", bus.done_o, bus.busy_o, bus.pass_o, bus.vec_out_o);
      end
   endtask

   task automatic test_stuck_zero();
      int n;
      for (int v = 0; v < NUM_VEC; v++) fault_m[v] = gate_nor(4'(v));
      model_sweep();
      do_start();
      wait_done(n);
      checks++;
      if (n !== SWEEP) begin
         errors++;
         $display("FAIL stuck_latency: got %0d want %0d", n, SWEEP);
      end
      checks++;
      if ({bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o, bus.pass_o} !== {5'(m_cnt), m_valid, m_vec, m_pass}) begin
         errors++;
         $display("FAIL stuck_result: got cnt=%0d valid=%b vec=%0d pass=%b want %0d %b %0d %b", bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o, bus.pass_o, m_cnt, m_valid, m_vec, m_pass);
      end
   endtask

   task automatic test_single_g();
      int n;
      clear_faults();
      fault_m[10] = 3'b001;
      model_sweep();
      do_start();
      checks++;
      if ({bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o, bus.pass_o} !== 11'd0) begin
         errors++;
         $display("FAIL start_clear: got cnt=%0d valid=%b vec=%0d pass=%b want all 0", bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o, bus.pass_o);
      end
      wait_done(n);
      checks++;
      if ({bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o, bus.pass_o} !== {5'(m_cnt), m_valid, m_vec, m_pass}) begin
         errors++;
         $display("FAIL single_g: got cnt=%0d valid=%b vec=%0d pass=%b want %0d %b %0d %b", bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o, bus.pass_o, m_cnt, m_valid, m_vec, m_pass);
      end
   endtask

   task automatic test_random_faults();
      int n;
      for (int r = 0; r < 4; r++) begin
         random_faults();
         model_sweep();
         do_start();
         wait_done(n);
         checks++;
         if (n !== SWEEP) begin
            errors++;
            $display("FAIL random_latency r=%0d: got %0d want %0d", r, n, SWEEP);
         end
         checks++;
         if ({bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o, bus.pass_o} !== {5'(m_cnt), m_valid, m_vec, m_pass}) begin
            errors++;
            $display("FAIL random_result r=%0d: got cnt=%0d valid=%b vec=%0d pass=%b want %0d %b %0d %b", r, bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o, bus.pass_o, m_cnt, m_valid, m_vec, m_pass);
         end
      end
   endtask

   task automatic test_abort();
      int n;
      clear_faults();
      fault_m[1] = 3'b100;
      model_sweep();
      do_start();
      for (int i = 0; i < 25; i++) tick();
      do_abort();
      checks++;
      if ({bus.vec_out_o, bus.busy_o, bus.done_o, bus.pass_o} !== 7'd0) begin
         errors++;
         $display("FAIL abort_ctrl: got vec=%0d busy=%b done=%b pass=%b want all 0", bus.vec_out_o, bus.busy_o, bus.done_o, bus.pass_o);
      end
      checks++;
      if ({bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o} !== {5'd1, 1'b1, 4'd1}) begin
         errors++;
         $display("FAIL abort_keep: got cnt=%0d valid=%b vec=%0d want 1 1 1", bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({bus.done_o, bus.busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL abort_quiet i=%0d: got done=%b busy=%b want 0 0", i, bus.done_o, bus.busy_o);
         end
      end
      bus.start_i = 1'b1;
      bus.abort_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      checks++;
      if (bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_beats_start: got busy=%b want 0", bus.busy_o);
      end
      do_start();
      wait_done(n);
      checks++;
      if ({n, bus.pass_o} !== {SWEEP, m_pass}) begin
         errors++;
         $display("FAIL abort_restart: got latency=%0d pass=%b want %0d %b", n, bus.pass_o, SWEEP, m_pass);
      end
      do_abort();
   endtask

   task automatic test_rst_and_busy_start();
      int n;
      clear_faults();
      fault_m[0] = 3'b010;
      do_start();
      for (int i = 0; i < 20; i++) tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.vec_out_o, bus.busy_o, bus.done_o, bus.pass_o, bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o} !== 17'd0) begin
         errors++;
         $display("FAIL rst_mid: got vec=%0d busy=%b done=%b pass=%b cnt=%0d valid=%b evec=%0d want all 0", bus.vec_out_o, bus.busy_o, bus.done_o, bus.pass_o, bus.err_cnt_o, bus.err_valid_o, bus.err_vec_o);
      end
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.busy_o, bus.done_o} !== 2'b00) begin
         errors++;
         $display("FAIL rst_stay_idle: got busy=%b done=%b want 0 0", bus.busy_o, bus.done_o);
      end
      clear_faults();
      do_start();
      for (int i = 0; i < 10; i++) tick();
      do_start();
      checks++;
      if (bus.vec_out_o !== 4'(11 / (H + 1))) begin
         errors++;
         $display("FAIL busy_start_vec: got %0d want %0d", bus.vec_out_o, 11 / (H + 1));
      end
      wait_done(n);
      checks++;
      if (n !== SWEEP - 11) begin
         errors++;
         $display("FAIL busy_start_latency: got %0d want %0d", n, SWEEP - 11);
      end
      do_abort();
   endtask

`ifdef NOR_SWEEP_LOOP_EN
   task automatic test_loop();
      int n;
      random_faults();
      do_start();
      for (int p = 0; p < 3; p++) begin
         model_sweep();
         wait_done(n);
         checks++;
         if ({n, bus.vec_out_o, bus.busy_o} !== {SWEEP, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL loop_wrap p=%0d: got latency=%0d vec=%0d busy=%b want %0d 0 1", p, n, bus.vec_out_o, bus.busy_o, SWEEP);
         end
         checks++;
         if ({bus.pass_o, bus.err_cnt_o, bus.err_valid_o} !== {m_pass, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL loop_result p=%0d: got pass=%b cnt=%0d valid=%b want %b 0 0", p, bus.pass_o, bus.err_cnt_o, bus.err_valid_o, m_pass);
         end
         random_faults();
      end
      tick();
      checks++;
      if (bus.done_o !== 1'b0) begin
         errors++;
         $display("FAIL loop_pulse: got done=%b want 0", bus.done_o);
      end
      do_abort();
   endtask
`endif

   initial begin
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      chk_v = 4'd0;
      clear_faults();
      test_reset();
      test_ref_model();
`ifdef NOR_SWEEP_LOOP_EN
      test_loop();
`else
      test_nominal();
      test_stuck_zero();
      test_single_g();
      test_random_faults();
`endif
      test_abort();
      test_rst_and_busy_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
